// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: FSM state codes, R/W bit values and
// the quarter-period index type used to sequence each bit slot.
package i2c_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_START = 3'd1;
    localparam state_t S_ADDR  = 3'd2;
    localparam state_t S_RW    = 3'd3;
    localparam state_t S_AACK  = 3'd4;
    localparam state_t S_DATA  = 3'd5;
    localparam state_t S_DACK  = 3'd6;
    localparam state_t S_STOP  = 3'd7;

    localparam logic I2C_RD = 1'b1;
    localparam logic I2C_WR = 1'b0;

    typedef logic [1:0] quarter_t;

    localparam quarter_t QTR_FIRST  = 2'd0;
    localparam quarter_t QTR_SAMPLE = 2'd2;
    localparam quarter_t QTR_LAST   = 2'd3;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Divides the system clock into SCL quarter periods: a one-cycle qtick every
// CLK_DIV clocks plus the index of the quarter currently in progress.
module i2c_qtick_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     enable,
    output logic     qtick,
    output quarter_t quarter
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign qtick = enable && (count == CNT_MAX);

    // Held at quarter 0 while disabled so a new frame always starts on a slot boundary.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            count   <= '0;
            quarter <= QTR_FIRST;
        end else if (qtick) begin
            count   <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-frame I2C master: START, address + R/W, ACK, one data word, ACK/NACK, STOP.
// SCL is push-pull; SDA is open-drain via sda_oe.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 6,
    parameter int CLK_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rw,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 ack_err,
    output logic                 scl_out,
    input  logic                 sda_in,
    output logic                 sda_out,
    output logic                 sda_oe
);

    localparam int MAX_BITS = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
    localparam int BIT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    state_t               state;
    quarter_t             quarter;
    logic                 qtick;
    logic                 slot_end;
    logic                 sample_pt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [ADDR_BITS-1:0] addr_sr;
    logic [DATA_BITS-1:0] wdata_sr;
    logic [DATA_BITS-1:0] rx_sr;
    logic                 rw_q;
    logic                 sampled;

    i2c_qtick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_qtick (
        .clk     (clk),
        .rst     (rst),
        .enable  (state != S_IDLE),
        .qtick   (qtick),
        .quarter (quarter)
    );

    assign slot_end  = qtick && (quarter == QTR_LAST);
    assign sample_pt = qtick && (quarter == QTR_SAMPLE);
    assign busy      = (state != S_IDLE);
    assign sda_out   = 1'b0;

    // Bus pins decode straight from state and quarter, so SDA moves only on Q0 entry
    // except for the deliberate transitions in the START and STOP slots.
    always_comb begin
        scl_out = 1'b1;
        sda_oe  = 1'b0;
        case (state)
            S_START: begin
                scl_out = (quarter != QTR_LAST);
                sda_oe  = quarter[1];
            end
            S_ADDR: begin
                scl_out = quarter[1];
                sda_oe  = !addr_sr[ADDR_BITS-1];
            end
            S_RW: begin
                scl_out = quarter[1];
                sda_oe  = !rw_q;
            end
            S_AACK, S_DACK: begin
                scl_out = quarter[1];
            end
            S_DATA: begin
                scl_out = quarter[1];
                sda_oe  = (rw_q == I2C_WR) && !wdata_sr[DATA_BITS-1];
            end
            S_STOP: begin
                scl_out = quarter[1];
                sda_oe  = (quarter != QTR_LAST);
            end
            default: begin
                scl_out = 1'b1;
                sda_oe  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            rdata    <= '0;
            bit_cnt  <= '0;
            addr_sr  <= '0;
            wdata_sr <= '0;
            rx_sr    <= '0;
            rw_q     <= I2C_WR;
            sampled  <= 1'b1;
        end else begin
            done <= 1'b0;
            if (sample_pt) begin
                sampled <= sda_in;
            end
            if (sample_pt && (state == S_DATA) && (rw_q == I2C_RD)) begin
                rx_sr <= {rx_sr[DATA_BITS-2:0], sda_in};
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_START;
                        addr_sr  <= addr;
                        rw_q     <= rw;
                        wdata_sr <= wdata;
                        rx_sr    <= '0;
                        ack_err  <= 1'b0;
                    end
                end
                S_START: begin
                    if (slot_end) begin
                        state   <= S_ADDR;
                        bit_cnt <= BIT_W'(ADDR_BITS - 1);
                    end
                end
                S_ADDR: begin
                    if (slot_end) begin
                        addr_sr <= addr_sr << 1;
                        if (bit_cnt == '0) begin
                            state <= S_RW;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                S_RW: begin
                    if (slot_end) begin
                        state <= S_AACK;
                    end
                end
                S_AACK: begin
                    // An unanswered address skips the data phase entirely.
                    if (slot_end) begin
                        if (sampled) begin
                            ack_err <= 1'b1;
                            state   <= S_STOP;
                        end else begin
                            state   <= S_DATA;
                            bit_cnt <= BIT_W'(DATA_BITS - 1);
                        end
                    end
                end
                S_DATA: begin
                    if (slot_end) begin
                        wdata_sr <= wdata_sr << 1;
                        if (bit_cnt == '0) begin
                            state <= S_DACK;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                S_DACK: begin
                    if (slot_end) begin
                        if ((rw_q == I2C_WR) && sampled) begin
                            ack_err <= 1'b1;
                        end
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (slot_end) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                        if (rw_q == I2C_RD) begin
                            rdata <= rx_sr;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a bus-level minion model answers on SDA while frames are
// predicted from the frame layout (bit sequence, duration, ack_err, rdata).
module tb_i2c_master_ctrl;

    localparam int ADDR_BITS = 4;
    localparam int DATA_BITS = 6;
    localparam int CLK_DIV   = 4;
    localparam int SLOT      = 4 * CLK_DIV;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 rw;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic [DATA_BITS-1:0] rdata;
    logic                 busy;
    logic                 done;
    logic                 ack_err;
    logic                 scl_out;
    logic                 sda_in;
    logic                 sda_out;
    logic                 sda_oe;

    int errors = 0;
    int checks = 0;

    logic [ADDR_BITS-1:0] minion_addr = 4'b0010;
    logic                 minion_on   = 1'b1;
    logic                 data_ack    = 1'b1;
    logic [DATA_BITS-1:0] minion_rd   = '0;

    logic                 drive_low  = 1'b0;
    logic                 prev_scl   = 1'b1;
    logic                 prev_sda   = 1'b1;
    logic                 active     = 1'b0;
    logic                 acked      = 1'b0;
    logic                 is_read    = 1'b0;
    logic [ADDR_BITS-1:0] addr_shift = '0;
    int                   edges      = 0;
    int                   violations = 0;
    bit                   seen[$];

    logic [DATA_BITS-1:0] rdata_model = '0;
    logic                 rdata_known = 1'b1;

    assign sda_in = ~(sda_oe | drive_low);

    always #5 clk = ~clk;

    i2c_master_ctrl #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .CLK_DIV   (CLK_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl_out (scl_out),
        .sda_in  (sda_in),
        .sda_out (sda_out),
        .sda_oe  (sda_oe)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Minion: watches the bus a moment after each clock edge, records SDA at every SCL
    // rise, and changes its own drive only while SCL is low.
    always @(posedge clk) begin
        int k;
        #1;
        if (rst) begin
            active    = 1'b0;
            drive_low = 1'b0;
            edges     = 0;
        end else if (prev_scl && scl_out && (prev_sda != sda_in)) begin
            if (!sda_in) begin
                if (active) violations++;
                active     = 1'b1;
                edges      = 0;
                acked      = 1'b0;
                is_read    = 1'b0;
                addr_shift = '0;
                seen.delete();
            end else begin
                if (!active) violations++;
                active = 1'b0;
            end
        end else if (active && !prev_scl && scl_out) begin
            seen.push_back(sda_in);
            edges++;
            if (edges <= ADDR_BITS) addr_shift = {addr_shift[ADDR_BITS-2:0], sda_in};
            else if (edges == ADDR_BITS + 1) is_read = sda_in;
        end else if (active && prev_scl && !scl_out) begin
            if (edges == ADDR_BITS + 1) begin
                acked     = minion_on && (addr_shift == minion_addr);
                drive_low = acked;
            end else if (edges >= ADDR_BITS + 2 && edges <= ADDR_BITS + DATA_BITS + 1) begin
                k = DATA_BITS - 1 - (edges - (ADDR_BITS + 2));
                drive_low = acked && is_read && !minion_rd[k];
            end else if (edges == ADDR_BITS + DATA_BITS + 2) begin
                drive_low = acked && !is_read && data_ack;
            end else begin
                drive_low = 1'b0;
            end
        end
        prev_scl = scl_out;
        prev_sda = ~(sda_oe | drive_low);
    end

    // Expected SDA value at every SCL rise, frame length and error flag from the frame layout.
    task automatic buildExpected(input logic [ADDR_BITS-1:0] a, input logic r, input logic [DATA_BITS-1:0] w,
                                 input logic [DATA_BITS-1:0] rv, input logic addr_ok, input logic dack,
                                 output logic [31:0] bits, output int nbits, output int clocks, output logic err);
        int slots;
        bits  = '0;
        nbits = 0;
        for (int i = ADDR_BITS - 1; i >= 0; i--) begin
            bits = {bits[30:0], a[i]};
            nbits++;
        end
        bits = {bits[30:0], r};
        bits = {bits[30:0], !addr_ok};
        nbits += 2;
        slots = 1 + ADDR_BITS + 1 + 1 + 1;
        if (addr_ok) begin
            for (int i = DATA_BITS - 1; i >= 0; i--) begin
                bits = {bits[30:0], (r ? rv[i] : w[i])};
                nbits++;
            end
            bits = {bits[30:0], (r ? 1'b1 : !dack)};
            nbits++;
            slots += DATA_BITS + 1;
        end
        bits = {bits[30:0], 1'b0};
        nbits++;
        clocks = slots * SLOT;
        err = !addr_ok || (!r && !dack);
    endtask

    task automatic applyStimulus(input logic [ADDR_BITS-1:0] a, input logic r, input logic [DATA_BITS-1:0] w,
                                 input logic [DATA_BITS-1:0] rv, input logic on, input logic dack,
                                 input int glitch_at);
        logic [31:0] exp_bits;
        logic [31:0] obs_bits;
        int          exp_n;
        int          exp_clocks;
        int          cycles;
        logic        exp_err;
        logic        addr_ok;
        addr_ok   = on && (a == minion_addr);
        minion_on = on;
        data_ack  = dack;
        minion_rd = rv;
        buildExpected(a, r, w, rv, addr_ok, dack, exp_bits, exp_n, exp_clocks, exp_err);
        @(negedge clk);
        violations = 0;
        start = 1'b1;
        rw    = r;
        addr  = a;
        wdata = w;
        @(posedge clk);
        #1;
        checkOutput("busy_after_start", busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
        addr  = ADDR_BITS'($urandom);
        wdata = DATA_BITS'($urandom);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == glitch_at) begin
                start = 1'b1;
                addr  = ~a;
                rw    = ~r;
            end else if (cycles == glitch_at + 1) begin
                start = 1'b0;
            end
        end while (!done && cycles < 1000);
        start = 1'b0;
        checkOutput("done_latency", cycles, exp_clocks);
        checkOutput("busy_at_done", busy, 1'b0);
        checkOutput("ack_err", ack_err, exp_err);
        if (r && addr_ok) begin
            rdata_model = rv;
            rdata_known = 1'b1;
        end else if (r) begin
            rdata_known = 1'b0;
        end
        if (rdata_known) checkOutput("rdata", rdata, rdata_model);
        obs_bits = '0;
        foreach (seen[i]) obs_bits = {obs_bits[30:0], seen[i]};
        checkOutput("sda_bit_count", seen.size(), exp_n);
        checkOutput("sda_bits", obs_bits, exp_bits);
        if (!addr_ok) checkOutput("nack_scl_rises", seen.size() - 1, ADDR_BITS + 2);
        checkOutput("sda_stable_scl_high", violations, 0);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", done, 1'b0);
        checkOutput("idle_after_done", busy, 1'b0);
        checkOutput("ack_err_held", ack_err, exp_err);
    endtask

    task automatic abortDuringData();
        minion_on = 1'b1;
        data_ack  = 1'b1;
        @(negedge clk);
        start = 1'b1;
        rw    = 1'b0;
        addr  = minion_addr;
        wdata = 6'h15;
        @(negedge clk);
        start = 1'b0;
        repeat (9 * SLOT + 3) @(negedge clk);
        checkOutput("busy_before_abort", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_scl", scl_out, 1'b1);
        checkOutput("abort_sda_oe", sda_oe, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_ack_err", ack_err, 1'b0);
        rdata_model = '0;
        rdata_known = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [ADDR_BITS-1:0] ra;
        rst   = 1'b1;
        start = 1'b0;
        rw    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_scl", scl_out, 1'b1);
        checkOutput("reset_sda_oe", sda_oe, 1'b0);
        checkOutput("reset_sda_out", sda_out, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_ack_err", ack_err, 1'b0);
        checkOutput("reset_rdata", rdata, '0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(4'b0010, 1'b0, 6'h2A, 6'h00, 1'b1, 1'b1, -1);
        applyStimulus(4'b0010, 1'b1, 6'h00, 6'b110011, 1'b1, 1'b1, -1);
        applyStimulus(4'b0101, 1'b0, 6'h11, 6'h00, 1'b1, 1'b1, -1);
        applyStimulus(4'b0010, 1'b0, 6'h3C, 6'h00, 1'b1, 1'b0, -1);
        applyStimulus(4'b0010, 1'b1, 6'h00, 6'h2D, 1'b1, 1'b1, 50);
        abortDuringData();
        applyStimulus(4'b0010, 1'b0, 6'h2A, 6'h00, 1'b1, 1'b1, -1);

        for (int n = 0; n < 20; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? ADDR_BITS'($urandom) : minion_addr;
            applyStimulus(ra, 1'($urandom_range(0, 1)), DATA_BITS'($urandom), DATA_BITS'($urandom),
                          ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 100)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
